diferenca_sequencial: RTL and testbench
=======================================

Name: diferenca_sequencial

Overview:
- Receiver/checker for the 8-bit accumulated-sum stream from the sequential adder: value(n+1) = value(n) + k, with k incrementing by 1 each sample, mod 2^LARGURA.
- Recovers each increment by subtraction: delta = current sample − previous sample.
- Compares each delta against an internally tracked expected increment, then reports lock state, the recovered delta, single-cycle error pulses and a saturating error count.
- Sits on the consumer side of the adder's saida bus, as a self-check / decoder in the datapath.

Parameters:
- LARGURA, 8, width of input samples, delta and expected-increment registers
- LARGURA_CONT, 8, width of sample index and error counters
- LIMITE_ERROS, 3, consecutive mismatches that force loss of lock (≥1)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- entrada  input  LARGURA  sample from the accumulator stream
- entrada_valida  input  1  entrada is consumed on this rising edge
- limpar  input  1  synchronous clear of erros
- delta  output  LARGURA  registered recovered increment
- delta_valido  output  1  one-cycle pulse; delta updated this cycle
- indice  output  LARGURA_CONT  count of accepted samples, wraps
- travado  output  1  tracker locked
- erro  output  1  one-cycle pulse on delta mismatch while locked
- erros  output  LARGURA_CONT  saturating mismatch count

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high, sampled on posedge clock.
  - Reset has priority over every other input.
  - No handshake back-pressure: every cycle with entrada_valida=1 accepts one sample.
  - Cycles with entrada_valida=0 change nothing; delta_valido and erro are 0 in those cycles.
- Reset values:
  - delta=0, delta_valido=0, indice=0, travado=0, erro=0, erros=0.
  - Internal: anterior=0, esperado=0, consecutivos=0, state=VAZIO.
- Every accepted sample:
  - anterior <= entrada.
  - indice <= indice+1 (wraps).
- Delta computation:
  - Computed only when a previous sample exists: delta = (entrada − anterior) mod 2^LARGURA.
  - Registered, so delta is visible the cycle after acceptance, with delta_valido=1 for exactly that cycle.
- VAZIO: accepted sample is stored only; no delta_valido → ADQUIRINDO.
- ADQUIRINDO: accepted sample produces delta and delta_valido.
  - esperado <= delta+1; consecutivos <= 0; travado <= 1 → RASTREANDO.
- RASTREANDO: accepted sample produces delta and delta_valido; esperado <= esperado+1 (mod 2^LARGURA) regardless of outcome.
  - delta == esperado → consecutivos <= 0.
  - delta != esperado → erro pulse (1 cycle), erros += 1 saturating at 2^LARGURA_CONT−1, consecutivos += 1.
  - If consecutivos reaches LIMITE_ERROS → PERDIDO, travado <= 0 in the same registered update as that erro pulse.
- PERDIDO: accepted sample produces delta and delta_valido with no comparison and no erro → ADQUIRINDO (resynchronise from the next delta).
- limpar:
  - erros <= 0.
  - If a mismatch occurs in the same cycle, limpar wins for the counter (erros=0), but the erro pulse is still emitted.
  - limpar does not affect state, travado or consecutivos.
- Arithmetic: all sample and delta arithmetic is modular at LARGURA bits, so stream wrap-around past 2^LARGURA−1 is not an error.
- Reset mid-stream: returns to VAZIO in one cycle. The next two samples re-acquire; no erro is raised during re-acquisition.

Test Plan:
- Nominal: after reset, feed 0,0,1,3,6,10,15 on consecutive cycles → delta sequence 0,1,2,3,4,5; travado=1 one cycle after the second sample; erro never asserted; erros=0; indice=7.
- Wrap: lock on 0,0,1,3,…, continue to 210,231,253,20,42 → deltas 21,22,23,22? No: 253→20 gives 23, 20→42 gives 22 mismatch only if the stream is corrupted; use the true stream 231,253,20,44 → deltas 22,23,24, no erro, travado stays 1.
- Single corruption: 0,0,1,3,7,10,15 → erro pulses on samples 7 and 10 (deltas 4 and 3 vs expected 3 and 4); delta 5 matches; travado stays 1; erros=2.
- Loss and relock: 5,5,5,5,5,12,20 → lock after second 5; three erro pulses; travado=0 after the fifth sample; sample 12 gives no erro; sample 20 gives delta 8, esperado=9, travado=1.
- Gaps and limpar: nominal stream with entrada_valida toggled 1,0,0,1 → outputs hold and no delta_valido in the idle cycles; then assert limpar in the same cycle as a mismatch → erro=1, erros=0 afterwards.
- Reset mid-stream: assert reset after sample 6 of the nominal stream, then feed 40,41,43 → all outputs 0 in the reset cycle; relock with esperado=2 after 41; no erro.

Source files
------------

// File: rtl/diferenca_sequencial_if.sv
// Bus between the accumulator stream and the sequential difference checker.
// slave = checker side, master = stream producer / observer side.
interface diferenca_sequencial_if #(
  parameter int LARGURA      = 8,
  parameter int LARGURA_CONT = 8
);
  logic [LARGURA-1:0]      entrada;
  logic                    entrada_valida;
  logic                    limpar;
  logic [LARGURA-1:0]      delta;
  logic                    delta_valido;
  logic [LARGURA_CONT-1:0] indice;
  logic                    travado;
  logic                    erro;
  logic [LARGURA_CONT-1:0] erros;

  modport slave (
    input  entrada, entrada_valida, limpar,
    output delta, delta_valido, indice, travado, erro, erros
  );

  modport master (
    output entrada, entrada_valida, limpar,
    input  delta, delta_valido, indice, travado, erro, erros
  );
endinterface

// File: rtl/diferenca_sequencial.sv
// Recovers increments of an accumulated-sum stream by subtraction and checks
// them against a self-incrementing expected increment.
//
// state      | meaning
// VAZIO      | no previous sample stored yet
// ADQUIRINDO | previous sample held; next delta seeds the expected increment
// RASTREANDO | locked; every delta is compared against esperado
// PERDIDO    | too many consecutive mismatches; next delta is discarded
module diferenca_sequencial #(
  parameter int LARGURA      = 8,
  parameter int LARGURA_CONT = 8,
  parameter int LIMITE_ERROS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  diferenca_sequencial_if.slave bus
);

  localparam int CW = (LIMITE_ERROS < 2) ? 1 : $clog2(LIMITE_ERROS + 1);
  localparam logic [CW-1:0]           LIMITE_C  = CW'(LIMITE_ERROS);
  localparam logic [LARGURA_CONT-1:0] ERROS_MAX = '1;

  typedef enum logic [1:0] {
    VAZIO      = 2'd0,
    ADQUIRINDO = 2'd1,
    RASTREANDO = 2'd2,
    PERDIDO    = 2'd3
  } estado_t;

  estado_t                 estado, estado_prox;
  logic [LARGURA-1:0]      anterior, anterior_prox;
  logic [LARGURA-1:0]      esperado, esperado_prox;
  logic [CW-1:0]           consecutivos, consecutivos_prox;
  logic [LARGURA-1:0]      delta_r, delta_prox;
  logic                    delta_valido_r, delta_valido_prox;
  logic [LARGURA_CONT-1:0] indice_r, indice_prox;
  logic                    travado_r, travado_prox;
  logic                    erro_r, erro_prox;
  logic [LARGURA_CONT-1:0] erros_r, erros_prox;
  logic [LARGURA-1:0]      diferenca;
  logic [CW-1:0]           consecutivos_inc;

  // Modular subtraction: stream wrap-around yields the true increment.
  assign diferenca        = bus.entrada - anterior;
  assign consecutivos_inc = consecutivos + CW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= VAZIO;
      anterior       <= '0;
      esperado       <= '0;
      consecutivos   <= '0;
      delta_r        <= '0;
      delta_valido_r <= 1'b0;
      indice_r       <= '0;
      travado_r      <= 1'b0;
      erro_r         <= 1'b0;
      erros_r        <= '0;
    end else begin
      estado         <= estado_prox;
      anterior       <= anterior_prox;
      esperado       <= esperado_prox;
      consecutivos   <= consecutivos_prox;
      delta_r        <= delta_prox;
      delta_valido_r <= delta_valido_prox;
      indice_r       <= indice_prox;
      travado_r      <= travado_prox;
      erro_r         <= erro_prox;
      erros_r        <= erros_prox;
    end
  end

  always_comb begin
    estado_prox       = estado;
    anterior_prox     = anterior;
    esperado_prox     = esperado;
    consecutivos_prox = consecutivos;
    delta_prox        = delta_r;
    delta_valido_prox = 1'b0;
    indice_prox       = indice_r;
    travado_prox      = travado_r;
    erro_prox         = 1'b0;
    erros_prox        = bus.limpar ? '0 : erros_r;

    if (bus.entrada_valida) begin
      anterior_prox = bus.entrada;
      indice_prox   = indice_r + LARGURA_CONT'(1);
      unique case (estado)
        VAZIO: begin
          estado_prox = ADQUIRINDO;
        end
        ADQUIRINDO: begin
          delta_prox        = diferenca;
          delta_valido_prox = 1'b1;
          esperado_prox     = diferenca + LARGURA'(1);
          consecutivos_prox = '0;
          travado_prox      = 1'b1;
          estado_prox       = RASTREANDO;
        end
        RASTREANDO: begin
          delta_prox        = diferenca;
          delta_valido_prox = 1'b1;
          esperado_prox     = esperado + LARGURA'(1);
          if (diferenca == esperado) begin
            consecutivos_prox = '0;
          end else begin
            erro_prox         = 1'b1;
            consecutivos_prox = consecutivos_inc;
            if (!bus.limpar && erros_r != ERROS_MAX)
              erros_prox = erros_r + LARGURA_CONT'(1);
            if (consecutivos_inc >= LIMITE_C) begin
              estado_prox  = PERDIDO;
              travado_prox = 1'b0;
            end
          end
        end
        PERDIDO: begin
          delta_prox        = diferenca;
          delta_valido_prox = 1'b1;
          estado_prox       = ADQUIRINDO;
        end
        default: estado_prox = VAZIO;
      endcase
    end
  end

  assign bus.delta        = delta_r;
  assign bus.delta_valido = delta_valido_r;
  assign bus.indice       = indice_r;
  assign bus.travado      = travado_r;
  assign bus.erro         = erro_r;
  assign bus.erros        = erros_r;

endmodule

// File: tb/tb_diferenca_sequencial.sv
// Scoreboard bench for diferenca_sequencial: directed streams push expected
// delta results; a negedge monitor pops and compares on each delta_valido.
module tb_diferenca_sequencial;

  logic clock;
  logic reset;

  diferenca_sequencial_if #(.LARGURA(8), .LARGURA_CONT(8)) bus ();

  diferenca_sequencial #(.LARGURA(8), .LARGURA_CONT(8), .LIMITE_ERROS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] delta;
    logic       erro;
    logic       travado;
    logic [7:0] erros;
    logic [7:0] indice;
  } esperado_t;

  esperado_t fila[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic void chk(string nome, int atual, int exigido);
    compared++;
    if (atual != exigido) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, exigido, $time);
    end
  endfunction

  // Monitor: outputs are registered on posedge, sampled on negedge.
  always @(negedge clock) begin
    esperado_t e;
    if (bus.delta_valido) begin
      if (fila.size() == 0) begin
        chk("unexpected_delta_valido", 1, 0);
      end else begin
        e = fila.pop_front();
        chk("delta",   int'(bus.delta),   int'(e.delta));
        chk("erro",    int'(bus.erro),    int'(e.erro));
        chk("travado", int'(bus.travado), int'(e.travado));
        chk("erros",   int'(bus.erros),   int'(e.erros));
        chk("indice",  int'(bus.indice),  int'(e.indice));
      end
    end else if (bus.erro) begin
      chk("erro_without_delta_valido", 1, 0);
    end
  end

  // One accepted sample; pushes the expected response when a delta is due.
  task automatic enviar(input logic [7:0] v, input logic lim, input logic tem_delta,
                        input logic [7:0] d, input logic er, input logic tr,
                        input logic [7:0] ers, input logic [7:0] idx);
    esperado_t e;
    if (tem_delta) begin
      e.delta = d; e.erro = er; e.travado = tr; e.erros = ers; e.indice = idx;
      fila.push_back(e);
    end
    bus.entrada        = v;
    bus.entrada_valida = 1'b1;
    bus.limpar         = lim;
    @(posedge clock);
    #1;
    bus.entrada_valida = 1'b0;
    bus.limpar         = 1'b0;
  endtask

  task automatic ocioso(input logic lim);
    bus.limpar = lim;
    @(posedge clock);
    #1;
    bus.limpar = 1'b0;
  endtask

  task automatic aplicar_reset(input string nome);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk({nome, "_delta"},        int'(bus.delta), 0);
    chk({nome, "_delta_valido"}, int'(bus.delta_valido), 0);
    chk({nome, "_indice"},       int'(bus.indice), 0);
    chk({nome, "_travado"},      int'(bus.travado), 0);
    chk({nome, "_erro"},         int'(bus.erro), 0);
    chk({nome, "_erros"},        int'(bus.erros), 0);
    reset = 1'b0;
  endtask

  task automatic dreno(input string nome);
    @(posedge clock);
    @(negedge clock);
    chk({nome, "_missing_outputs"}, fila.size(), 0);
  endtask

  initial begin
    logic [7:0] v;
    bus.entrada        = '0;
    bus.entrada_valida = 1'b0;
    bus.limpar         = 1'b0;
    reset              = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    aplicar_reset("reset");

    // Nominal stream
    enviar(8'd0,  0, 0, 0, 0, 0, 0, 0);
    chk("first_sample_indice",  int'(bus.indice), 1);
    chk("first_sample_travado", int'(bus.travado), 0);
    enviar(8'd0,  0, 1, 8'd0, 0, 1, 8'd0, 8'd2);
    enviar(8'd1,  0, 1, 8'd1, 0, 1, 8'd0, 8'd3);
    enviar(8'd3,  0, 1, 8'd2, 0, 1, 8'd0, 8'd4);
    enviar(8'd6,  0, 1, 8'd3, 0, 1, 8'd0, 8'd5);
    enviar(8'd10, 0, 1, 8'd4, 0, 1, 8'd0, 8'd6);
    enviar(8'd15, 0, 1, 8'd5, 0, 1, 8'd0, 8'd7);

    // Gaps: outputs hold, no pulses
    ocioso(1'b0);
    chk("gap_delta_valido", int'(bus.delta_valido), 0);
    chk("gap_delta",        int'(bus.delta), 5);
    chk("gap_indice",       int'(bus.indice), 7);
    ocioso(1'b0);
    chk("gap2_travado",     int'(bus.travado), 1);
    enviar(8'd21, 0, 1, 8'd6, 0, 1, 8'd0, 8'd8);
    enviar(8'd29, 0, 1, 8'd8, 1, 1, 8'd1, 8'd9);
    enviar(8'd37, 0, 1, 8'd8, 0, 1, 8'd1, 8'd10);
    // limpar coincident with mismatch: pulse kept, counter cleared
    enviar(8'd40, 1, 1, 8'd3, 1, 1, 8'd0, 8'd11);
    ocioso(1'b0);
    chk("after_limpar_erros", int'(bus.erros), 0);
    dreno("nominal");

    // Wrap-around: triangular numbers mod 256 through 231,253,20,44
    aplicar_reset("reset_wrap");
    for (int i = 0; i <= 25; i++) begin
      v = 8'((i * (i - 1)) / 2);
      if (i == 0) enviar(v, 0, 0, 0, 0, 0, 0, 0);
      else        enviar(v, 0, 1, 8'(i - 1), 0, 1, 8'd0, 8'(i + 1));
    end
    chk("wrap_last_sample_travado", int'(bus.travado), 1);
    dreno("wrap");

    // Single corruption
    aplicar_reset("reset_corr");
    enviar(8'd0,  0, 0, 0, 0, 0, 0, 0);
    enviar(8'd0,  0, 1, 8'd0, 0, 1, 8'd0, 8'd2);
    enviar(8'd1,  0, 1, 8'd1, 0, 1, 8'd0, 8'd3);
    enviar(8'd3,  0, 1, 8'd2, 0, 1, 8'd0, 8'd4);
    enviar(8'd7,  0, 1, 8'd4, 1, 1, 8'd1, 8'd5);
    enviar(8'd10, 0, 1, 8'd3, 1, 1, 8'd2, 8'd6);
    enviar(8'd15, 0, 1, 8'd5, 0, 1, 8'd2, 8'd7);
    dreno("corr");

    // Loss of lock and re-acquisition
    aplicar_reset("reset_loss");
    enviar(8'd5,  0, 0, 0, 0, 0, 0, 0);
    enviar(8'd5,  0, 1, 8'd0, 0, 1, 8'd0, 8'd2);
    enviar(8'd5,  0, 1, 8'd0, 1, 1, 8'd1, 8'd3);
    enviar(8'd5,  0, 1, 8'd0, 1, 1, 8'd2, 8'd4);
    enviar(8'd5,  0, 1, 8'd0, 1, 0, 8'd3, 8'd5);
    enviar(8'd12, 0, 1, 8'd7, 0, 0, 8'd3, 8'd6);
    enviar(8'd20, 0, 1, 8'd8, 0, 1, 8'd3, 8'd7);
    enviar(8'd29, 0, 1, 8'd9, 0, 1, 8'd3, 8'd8);
    ocioso(1'b1);
    chk("idle_limpar_erros",   int'(bus.erros), 0);
    chk("idle_limpar_travado", int'(bus.travado), 1);
    dreno("loss");

    // Reset mid-stream then re-acquire
    aplicar_reset("reset_mid_pre");
    enviar(8'd0,  0, 0, 0, 0, 0, 0, 0);
    enviar(8'd0,  0, 1, 8'd0, 0, 1, 8'd0, 8'd2);
    enviar(8'd1,  0, 1, 8'd1, 0, 1, 8'd0, 8'd3);
    enviar(8'd3,  0, 1, 8'd2, 0, 1, 8'd0, 8'd4);
    enviar(8'd6,  0, 1, 8'd3, 0, 1, 8'd0, 8'd5);
    enviar(8'd10, 0, 1, 8'd4, 0, 1, 8'd0, 8'd6);
    aplicar_reset("reset_mid");
    enviar(8'd40, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_first_travado", int'(bus.travado), 0);
    enviar(8'd41, 0, 1, 8'd1, 0, 1, 8'd0, 8'd2);
    enviar(8'd43, 0, 1, 8'd2, 0, 1, 8'd0, 8'd3);
    dreno("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
